// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display driver: active-low segment
// codes for hex digits (seg[0]=a .. seg[6]=g) and the lookup helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment scanner with frame-aligned data loads.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    load_done,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    import seg7_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic       tick;
    logic       boundary;
    logic [3:0] nibble;
    logic [6:0] seg_dec;
    logic       blank;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign nibble   = disp_val[idx*4 +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this nibble and every higher one are zero.
    always_comb begin
        blank = 1'b0;
        if (idx != '0)
            blank = ((disp_val >> {idx, 2'b00}) == '0);
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            load_done  <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
            end

            // A load coinciding with the boundary bypasses the shadow.
            load_done <= boundary && (load || pending);
            if (boundary && load) begin
                disp_val <= value;
                disp_dp  <= dp_mask;
                pending  <= 1'b0;
            end else if (boundary && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
                pending  <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            // One blank anode cycle after every tick to avoid ghosting.
            an  <= tick ? '1 : ~(AN_ONE << idx);
            seg <= blank ? SEG_BLANK : seg_dec;
            dp  <= ~disp_dp[idx];
        end
    end

endmodule
